// File: rtl/seq_mult_ram_if.sv
// Request/response bundle for seq_mult_ram: operand fetch, writeback address,
// RAM read port and the start/busy/done handshake.
interface seq_mult_ram_if #(
  parameter int unsigned W  = 4,
  parameter int unsigned RA = 3,
  parameter int unsigned DA = 3
);
  logic            start;
  logic            sgn;
  logic [RA-1:0]   ra1;
  logic [RA-1:0]   ra2;
  logic [DA-1:0]   dest_adr;
  logic            clear_mem;
  logic [DA-1:0]   rd_adr;
  logic [2*W-1:0]  rd_data;
  logic            busy;
  logic            done;
  logic [2*W-1:0]  result;

  modport master (
    output start, sgn, ra1, ra2, dest_adr, clear_mem, rd_adr,
    input  rd_data, busy, done, result
  );

  modport slave (
    input  start, sgn, ra1, ra2, dest_adr, clear_mem, rd_adr,
    output rd_data, busy, done, result
  );
endinterface

// File: rtl/seq_mult_ram.sv
// Sequential shift-add multiplier: operands from a constant ROM, 2W-bit product
// written to a result RAM with a registered read port.
module seq_mult_ram #(
  parameter int unsigned           W         = 4,
  parameter int unsigned           ROM_DEPTH = 8,
  parameter int unsigned           RAM_DEPTH = 8,
  parameter logic [ROM_DEPTH*W-1:0] ROM_DATA = {4'hF, 4'hA, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0}
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  seq_mult_ram_if.slave bus_io
);
  localparam int unsigned RA   = $clog2(ROM_DEPTH);
  localparam int unsigned DA   = $clog2(RAM_DEPTH);
  localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StMult, StWrite} state_e;

  state_e             state_q, state_d;
  logic [RA-1:0]      ra1_q, ra1_d, ra2_q, ra2_d;
  logic [DA-1:0]      dest_q, dest_d;
  logic               sgn_q, sgn_d, neg_q, neg_d, done_q, done_d;
  logic [2*W-1:0]     mcand_q, mcand_d, acc_q, acc_d, result_q, result_d, rd_data_q, prod;
  logic [W-1:0]       mplier_q, mplier_d, op_a, op_b, mag_a, mag_b;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               we;
  logic [W-1:0]       rom [ROM_DEPTH];
  logic [2*W-1:0]     mem_q [RAM_DEPTH];

  always_comb begin
    for (int i = 0; i < int'(ROM_DEPTH); i++) rom[i] = ROM_DATA[i*W +: W];
  end

  assign op_a  = rom[ra1_q];
  assign op_b  = rom[ra2_q];
  // In signed mode the most negative value maps to 2^(W-1), which still fits in W unsigned bits.
  assign mag_a = (sgn_q && op_a[W-1]) ? (~op_a + W'(1)) : op_a;
  assign mag_b = (sgn_q && op_b[W-1]) ? (~op_b + W'(1)) : op_b;
  assign prod  = neg_q ? ((2*W)'(0) - acc_q) : acc_q;

  always_comb begin
    state_d  = state_q;
    ra1_d    = ra1_q;
    ra2_d    = ra2_q;
    dest_d   = dest_q;
    sgn_d    = sgn_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    we       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          ra1_d   = bus_io.ra1;
          ra2_d   = bus_io.ra2;
          dest_d  = bus_io.dest_adr;
          sgn_d   = bus_io.sgn;
          state_d = StLoad;
        end
      end
      StLoad: begin
        mcand_d  = {{W{1'b0}}, mag_a};
        mplier_d = mag_b;
        neg_d    = sgn_q & (op_a[W-1] ^ op_b[W-1]);
        acc_d    = '0;
        cnt_d    = '0;
        state_d  = StMult;
      end
      StMult: begin
        if (mplier_q[0]) acc_d = acc_q + (mcand_q << cnt_q);
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntW'(W - 1)) state_d = StWrite;
      end
      StWrite: begin
        result_d = prod;
        done_d   = 1'b1;
        we       = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      ra1_q    <= '0;
      ra2_q    <= '0;
      dest_q   <= '0;
      sgn_q    <= 1'b0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ra1_q    <= ra1_d;
      ra2_q    <= ra2_d;
      dest_q   <= dest_d;
      sgn_q    <= sgn_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // Result RAM has no reset; a clear on the same edge as a write takes priority.
  always_ff @(posedge clk_i) begin
    if (bus_io.clear_mem) begin
      for (int i = 0; i < int'(RAM_DEPTH); i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[dest_q] <= prod;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rd_data_q <= '0;
    else         rd_data_q <= mem_q[bus_io.rd_adr];
  end

  assign bus_io.rd_data = rd_data_q;
  assign bus_io.busy    = (state_q != StIdle);
  assign bus_io.done    = done_q;
  assign bus_io.result  = result_q;
endmodule
